// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared fetch-stage widths, reset PC and packet types
package proc_pkg;

   localparam int ADDR_W   = 8;
   localparam int INSTR_W  = 16;
   localparam int RESET_PC = 0;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with combinational head and flush
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, credit-based imem issue and prefetch buffer
// An empty FIFO is bypassed so a returning word reaches decode the cycle it arrives.
module instr_fetch_unit #(
   parameter int ADDR_W     = proc_pkg::ADDR_W,
   parameter int INSTR_W    = proc_pkg::INSTR_W,
   parameter int RESET_PC   = proc_pkg::RESET_PC,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               CLOCK_50,
   input  logic               rst,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PKT_W = INSTR_W + ADDR_W;

   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] fpc_q;
   logic              inflight;

   logic              resp;
   logic              bypass;
   logic              pop;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [PKT_W-1:0]  fifo_head;
   logic [PKT_W-1:0]  head;
   logic [CW:0]       occupancy;

   assign resp        = inflight & ~redirect & ~rst;
   assign bypass      = fifo_empty & resp;
   assign instr_valid = (~fifo_empty | resp) & ~rst;
   assign head        = fifo_empty ? {imem_rdata, fpc_q} : fifo_head;
   assign {instr, instr_pc} = instr_valid ? head : '0;

   assign pop       = instr_valid & instr_ready & ~redirect;
   assign fifo_pop  = pop & ~fifo_empty;
   assign fifo_push = resp & ~(bypass & pop) & (~fifo_full | fifo_pop);

   // Credits: words that will still be held after this cycle, plus the one in flight.
   assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign imem_en   = ~rst & ~redirect & ~halt & (occupancy < (CW+1)'(FIFO_DEPTH));
   assign imem_addr = rst ? ADDR_W'(RESET_PC) : fpc;

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         fpc      <= ADDR_W'(RESET_PC);
         fpc_q    <= ADDR_W'(RESET_PC);
         inflight <= 1'b0;
      end else if (redirect) begin
         fpc      <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_en;
         if (imem_en) begin
            fpc   <= fpc + 1'b1;
            fpc_q <= fpc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PKT_W)
   ) u_fifo (
      .clk   (CLOCK_50),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect),
      .wdata ({imem_rdata, fpc_q}),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule
